shape_op_sequencer: RTL and testbench

Command sequencer in front of the shared shape-processor datapath. Accepts CTRL SFR write commands from `NUM_REQ` requesters and arbitrates between them round-robin. Resolves KEEP fields against the current configuration, rejects illegal commands, and otherwise drives one datapath operation at a time through a start/done handshake. Returns status and result to the originating requester, and holds the committed SHAPE/OPERATION configuration.

---
 rtl/shape_op_sequencer_pkg.sv | 64 ++++++
 rtl/shape_rr_arbiter.sv | 56 +++++
 rtl/shape_op_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_shape_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_op_sequencer_pkg.sv
// Shared shape-processor definitions.
// Holds the CTRL SFR layout, the SHAPE / OPERATION encodings (including the
// KEEP codes), the response status codes and the legality helpers used when
// a command is resolved against the committed configuration.
package shape_op_sequencer_pkg;

    typedef enum logic [1:0] {
        SHAPE_CIRCLE    = 2'b00,
        SHAPE_RECTANGLE = 2'b01,
        SHAPE_TRIANGLE  = 2'b10,
        SHAPE_KEEP      = 2'b11
    } shape_e;

    typedef enum logic [4:0] {
        OP_PERIMETER      = 5'h00,
        OP_AREA           = 5'h01,
        OP_IS_SQUARE      = 5'h08,
        OP_IS_EQUILATERAL = 5'h10,
        OP_IS_ISOSCELES   = 5'h11,
        OP_KEEP           = 5'h1F
    } operation_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_ILLEGAL = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_status_e;

    // CTRL SFR image: SHAPE in [17:16], OPERATION in [4:0], rest reserved.
    typedef struct packed {
        logic [13:0] rsvd_hi;
        logic [1:0]  shape;
        logic [10:0] rsvd_mid;
        logic [4:0]  operation;
    } ctrl_sfr_t;

    // Raw SHAPE field is a defined encoding (KEEP included).
    function automatic logic shape_is_legal(input logic [1:0] shape);
        case (shape)
            SHAPE_CIRCLE, SHAPE_RECTANGLE, SHAPE_TRIANGLE, SHAPE_KEEP: shape_is_legal = 1'b1;
            default: shape_is_legal = 1'b0;
        endcase
    endfunction

    // Raw OPERATION field is a defined encoding (KEEP included).
    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_PERIMETER, OP_AREA, OP_IS_SQUARE,
            OP_IS_EQUILATERAL, OP_IS_ISOSCELES, OP_KEEP: op_is_legal = 1'b1;
            default: op_is_legal = 1'b0;
        endcase
    endfunction

    // Resolved SHAPE/OPERATION pair is meaningful for the datapath.
    function automatic logic combo_is_legal(input logic [1:0] shape, input logic [4:0] op);
        case (op)
            OP_PERIMETER, OP_AREA:              combo_is_legal = 1'b1;
            OP_IS_SQUARE:                       combo_is_legal = (shape == SHAPE_RECTANGLE);
            OP_IS_EQUILATERAL, OP_IS_ISOSCELES: combo_is_legal = (shape == SHAPE_TRIANGLE);
            default:                            combo_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shape_rr_arbiter.sv
// Round-robin one-hot arbiter.
// Ports: clk/rst (async active-high), en (arbitration allowed this cycle),
// req (request vector), grant (one-hot, combinational), grant_idx (index of
// the granted requester). The pointer moves past the winner on every grant.
module shape_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan from the pointer and take the first asserted request
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (en && !found_s && req[cand_s]) begin
                found_s        = 1'b1;
                grant[cand_s]  = 1'b1;
                grant_idx      = cand_s;
            end
        end
    end

    // A grant is always an accept, so the pointer advances on any grant
    always_comb begin
        if (found_s) begin
            ptr_d = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shape_op_sequencer.sv
// Command sequencer in front of the shared shape-processor datapath.
// Ports: req_valid/req_data/req_ready - per-requester CTRL SFR writes;
// rsp_* - response (status, result, requester id) with valid/ready;
// dp_* - datapath start/done handshake with resolved SHAPE/OPERATION;
// cur_shape/cur_operation - committed configuration; busy - not IDLE.
// Optional feature: define SHAPE_SEQ_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); without it WAIT waits for dp_done indefinitely.
module shape_op_sequencer
    import shape_op_sequencer_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int RESULT_W       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [1:0]                 rsp_status,
    output logic [RESULT_W-1:0]        rsp_result,
    input  logic                       rsp_ready,
    output logic                       dp_start,
    output logic [1:0]                 dp_shape,
    output logic [4:0]                 dp_operation,
    input  logic                       dp_done,
    input  logic [RESULT_W-1:0]        dp_result,
    output logic [1:0]                 cur_shape,
    output logic [4:0]                 cur_operation,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESOLVE = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [1:0]          cmd_shape_q, cmd_shape_d;
    logic [4:0]          cmd_op_q, cmd_op_d;
    logic [ID_W-1:0]     req_id_q, req_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [1:0]          rsp_status_q, rsp_status_d;
    logic [RESULT_W-1:0] rsp_result_q, rsp_result_d;
    logic                dp_start_q, dp_start_d;
    logic [1:0]          dp_shape_q, dp_shape_d;
    logic [4:0]          dp_op_q, dp_op_d;
    logic [1:0]          cur_shape_q, cur_shape_d;
    logic [4:0]          cur_op_q, cur_op_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                accept_s;
    logic [31:0]         cmd_raw_s;
    ctrl_sfr_t           cmd_sel_s;
    logic [1:0]          res_shape_s;
    logic [4:0]          res_op_s;
    logic                legal_s;
    logic                unused_rsvd_s;

`ifdef SHAPE_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

    shape_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == ST_IDLE),
        .req       (req_valid),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // Pick the granted requester's SFR image out of the flat bus
    always_comb begin
        cmd_raw_s = 32'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_raw_s = cmd_raw_s | (req_data[32*i +: 32] & {32{grant_s[i]}});
        end
    end

    assign cmd_sel_s     = cmd_raw_s;
    assign unused_rsvd_s = ^{cmd_sel_s.rsvd_hi, cmd_sel_s.rsvd_mid};

    // KEEP fields take the committed value; raw fields are checked before resolution
    always_comb begin
        res_shape_s = (cmd_shape_q == SHAPE_KEEP) ? cur_shape_q : cmd_shape_q;
        res_op_s    = (cmd_op_q == OP_KEEP) ? cur_op_q : cmd_op_q;
        legal_s     = shape_is_legal(cmd_shape_q) && op_is_legal(cmd_op_q) &&
                      combo_is_legal(res_shape_s, res_op_s);
    end

    // Sequencer FSM and next values of all registered outputs
    always_comb begin
        state_d      = state_q;
        cmd_shape_d  = cmd_shape_q;
        cmd_op_d     = cmd_op_q;
        req_id_d     = req_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_status_d = rsp_status_q;
        rsp_result_d = rsp_result_q;
        dp_start_d   = 1'b0;
        dp_shape_d   = dp_shape_q;
        dp_op_d      = dp_op_q;
        cur_shape_d  = cur_shape_q;
        cur_op_d     = cur_op_q;
`ifdef SHAPE_SEQ_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cmd_shape_d = cmd_sel_s.shape;
                    cmd_op_d    = cmd_sel_s.operation;
                    req_id_d    = grant_idx_s;
                    state_d     = ST_RESOLVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESOLVE: begin
                if (legal_s) begin
                    dp_start_d = 1'b1;
                    dp_shape_d = res_shape_s;
                    dp_op_d    = res_op_s;
                    state_d    = ST_START;
                end else begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = req_id_q;
                    rsp_status_d = RSP_ILLEGAL;
                    rsp_result_d = '0;
                    state_d      = ST_RESP;
                end
            end
            ST_START: begin
`ifdef SHAPE_SEQ_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // dp_done wins over a watchdog expiry in the same cycle
                if (dp_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = req_id_q;
                    rsp_status_d = RSP_OK;
                    rsp_result_d = dp_result;
                    cur_shape_d  = dp_shape_q;
                    cur_op_d     = dp_op_q;
                    state_d      = ST_RESP;
`ifdef SHAPE_SEQ_TIMEOUT_EN
                end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th WAIT cycle without dp_done
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = req_id_q;
                    rsp_status_d = RSP_TIMEOUT;
                    rsp_result_d = '0;
                    state_d      = ST_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                    state_d  = ST_WAIT;
                end
`else
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_shape_q  <= SHAPE_RECTANGLE;
            cmd_op_q     <= OP_PERIMETER;
            req_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_status_q <= RSP_OK;
            rsp_result_q <= '0;
            dp_start_q   <= 1'b0;
            dp_shape_q   <= SHAPE_RECTANGLE;
            dp_op_q      <= OP_PERIMETER;
            cur_shape_q  <= SHAPE_RECTANGLE;
            cur_op_q     <= OP_PERIMETER;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_shape_q  <= cmd_shape_d;
            cmd_op_q     <= cmd_op_d;
            req_id_q     <= req_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_status_q <= rsp_status_d;
            rsp_result_q <= rsp_result_d;
            dp_start_q   <= dp_start_d;
            dp_shape_q   <= dp_shape_d;
            dp_op_q      <= dp_op_d;
            cur_shape_q  <= cur_shape_d;
            cur_op_q     <= cur_op_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SHAPE_SEQ_TIMEOUT_EN
    // Watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_result    = rsp_result_q;
    assign dp_start      = dp_start_q;
    assign dp_shape      = dp_shape_q;
    assign dp_operation  = dp_op_q;
    assign cur_shape     = cur_shape_q;
    assign cur_operation = cur_op_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_shape_op_sequencer.sv
// Self-checking bench for shape_op_sequencer: directed cases plus randomized
// commands checked against a behavioural model of arbitration, KEEP
// resolution, legality and committed configuration.
module tb_shape_op_sequencer;

    localparam int N  = 2;
    localparam int RW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [0:0]      rsp_id;
    logic [1:0]      rsp_status;
    logic [RW-1:0]   rsp_result;
    logic            rsp_ready;
    logic            dp_start;
    logic [1:0]      dp_shape;
    logic [4:0]      dp_operation;
    logic            dp_done;
    logic [RW-1:0]   dp_result;
    logic [1:0]      cur_shape;
    logic [4:0]      cur_operation;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    int exp_ptr;
    int exp_cur_shape;
    int exp_cur_op;

    shape_op_sequencer #(
        .NUM_REQ        (N),
        .RESULT_W       (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_status    (rsp_status),
        .rsp_result    (rsp_result),
        .rsp_ready     (rsp_ready),
        .dp_start      (dp_start),
        .dp_shape      (dp_shape),
        .dp_operation  (dp_operation),
        .dp_done       (dp_done),
        .dp_result     (dp_result),
        .cur_shape     (cur_shape),
        .cur_operation (cur_operation),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int shape, input int op);
        logic [31:0] d;
        d = $urandom;
        d[17:16] = 2'(shape);
        d[4:0]   = 5'(op);
        return d;
    endfunction

    function automatic int model_grant(input logic [1:0] vm);
        for (int k = 0; k < N; k++) begin
            if (vm[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return 0;
    endfunction

    // circle=0 rect=1 tri=2; perimeter=0 area=1 square=8 equilateral=16 isosceles=17 keep=31
    function automatic bit model_legal(input int rs, input int ro, input int raw_op);
        if (!(raw_op inside {0, 1, 8, 16, 17, 31})) return 1'b0;
        if (ro == 0 || ro == 1) return 1'b1;
        if (ro == 8) return rs == 1;
        if (ro == 16 || ro == 17) return rs == 2;
        return 1'b0;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rspv"},  64'(rsp_valid), 64'(0));
        check({tag, "_rspid"}, 64'(rsp_id), 64'(0));
        check({tag, "_stat"},  64'(rsp_status), 64'(0));
        check({tag, "_res"},   64'(rsp_result), 64'(0));
        check({tag, "_start"}, 64'(dp_start), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_cshp"},  64'(cur_shape), 64'(1));
        check({tag, "_cop"},   64'(cur_operation), 64'(0));
        check({tag, "_dshp"},  64'(dp_shape), 64'(1));
        check({tag, "_dop"},   64'(dp_operation), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; dp_done = 1'b0; dp_result = '0;
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0; exp_cur_shape = 1; exp_cur_op = 0;
    endtask

    task automatic idle_step();
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = '0;
        #1;
        check("idle_rspv", 64'(rsp_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_ready", 64'(req_ready), 64'(0));
    endtask

    // One full command: grant, resolve, optional datapath run, response.
    task automatic do_txn(input logic [1:0] vm, input logic [31:0] d0, input logic [31:0] d1,
                          input int lat, input int rdly, input logic [RW-1:0] res, input bit early_done);
        int g, rs, ro, est;
        bit ok;
        logic [31:0] d;
        logic [RW-1:0] eres;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = vm;
        req_data  = {d1, d0};
        #1;
        g = model_grant(vm);
        check("grant", 64'(req_ready), 64'(1 << g));
        exp_ptr = (g + 1) % N;
        d  = (g == 0) ? d0 : d1;
        rs = (d[17:16] == 2'b11) ? exp_cur_shape : int'(d[17:16]);
        ro = (d[4:0] == 5'h1F) ? exp_cur_op : int'(d[4:0]);
        ok = model_legal(rs, ro, int'(d[4:0]));
        @(negedge clk);
        check("c1_ready", 64'(req_ready), 64'(0));
        check("c1_busy", 64'(busy), 64'(1));
        check("c1_start", 64'(dp_start), 64'(0));
        check("c1_rspv", 64'(rsp_valid), 64'(0));
        if (!ok) begin
            est = 1; eres = '0;
            @(negedge clk);
            check("ill_start", 64'(dp_start), 64'(0));
        end else begin
            est = 0; eres = res;
            @(negedge clk);
            check("c2_start", 64'(dp_start), 64'(1));
            check("c2_shape", 64'(dp_shape), 64'(rs));
            check("c2_op", 64'(dp_operation), 64'(ro));
            if (early_done) begin
                dp_done = 1'b1; dp_result = ~res;
            end
            for (int i = 1; i < lat; i++) begin
                @(negedge clk);
                dp_done = 1'b0;
                check("wait_start", 64'(dp_start), 64'(0));
                check("wait_rspv", 64'(rsp_valid), 64'(0));
                check("wait_shape", 64'(dp_shape), 64'(rs));
            end
            @(negedge clk);
            check("pre_cur_shape", 64'(cur_shape), 64'(exp_cur_shape));
            dp_done = 1'b1; dp_result = res;
            @(negedge clk);
            dp_done = 1'b0; dp_result = '0;
            exp_cur_shape = rs; exp_cur_op = ro;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("rsp_status", 64'(rsp_status), 64'(est));
        check("rsp_result", 64'(rsp_result), 64'(eres));
        check("cur_shape", 64'(cur_shape), 64'(exp_cur_shape));
        check("cur_op", 64'(cur_operation), 64'(exp_cur_op));
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("hold_rspv", 64'(rsp_valid), 64'(1));
            check("hold_id", 64'(rsp_id), 64'(g));
            check("hold_stat", 64'(rsp_status), 64'(est));
            check("hold_res", 64'(rsp_result), 64'(eres));
            check("hold_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        int ops [8];
        logic [1:0] vm;
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        dp_done = 1'b0; dp_result = '0;
        exp_ptr = 0; exp_cur_shape = 1; exp_cur_op = 0;
        repeat (2) @(negedge clk);
        check_reset_values("init");
        rst = 1'b0;

        // Triangle / is-equilateral, result 1 after 3 cycles
        do_txn(2'b01, mk(2, 16), mk(1, 0), 3, 0, 32'd1, 1'b0);
        idle_step();
        check("tp1_cur_shape", 64'(cur_shape), 64'(2));
        check("tp1_cur_op", 64'(cur_operation), 64'(16));

        // KEEP shape after reset resolves to rectangle
        do_reset();
        do_txn(2'b01, mk(3, 8), mk(0, 0), 2, 0, 32'hABCD, 1'b0);
        idle_step();
        check("keep_cur_op", 64'(cur_operation), 64'(8));

        // Illegal combinations
        do_txn(2'b10, mk(0, 0), mk(2, 8), 1, 1, 32'h0, 1'b0);
        idle_step();
        do_txn(2'b01, mk(1, 5), mk(0, 0), 1, 0, 32'h0, 1'b0);
        idle_step();

        // Both requesters continuously valid: alternate grants
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, mk(1, 1), mk(0, 0), 1 + i, i % 2, $urandom, 1'b0);
        end

        // Long response stall, then an early dp_done that must be ignored
        do_txn(2'b11, mk(2, 17), mk(3, 31), 2, 10, 32'h1234_5678, 1'b0);
        do_txn(2'b10, mk(0, 0), mk(0, 1), 3, 0, 32'h55AA_0F0F, 1'b1);
        idle_step();

        // Randomized commands
        ops = '{0, 1, 8, 16, 17, 31, 5, 0};
        for (int n = 0; n < 40; n++) begin
            vm = 2'($urandom_range(1, 3));
            ops[7] = $urandom_range(0, 31);
            do_txn(vm, mk($urandom_range(0, 3), ops[$urandom_range(0, 7)]),
                   mk($urandom_range(0, 3), ops[$urandom_range(0, 7)]),
                   $urandom_range(1, 5), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        // Reset during WAIT: everything back to reset values, no response
        @(negedge clk);
        req_valid = 2'b01; req_data = {mk(0, 0), mk(1, 1)};
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rw_start", 64'(dp_start), 64'(1));
        @(negedge clk);
        check("rw_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check_reset_values("rw");
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0; exp_cur_shape = 1; exp_cur_op = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rw_norsp", 64'(rsp_valid), 64'(0));
            check("rw_idle", 64'(busy), 64'(0));
        end

`ifdef SHAPE_SEQ_TIMEOUT_EN
        // No dp_done: status 2 after TO WAIT cycles, configuration unchanged
        @(negedge clk);
        req_valid = 2'b01; req_data = {mk(0, 0), mk(2, 17)};
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("to_start", 64'(dp_start), 64'(1));
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_wait", 64'(rsp_valid), 64'(0));
        end
        @(negedge clk);
        check("to_rspv", 64'(rsp_valid), 64'(1));
        check("to_stat", 64'(rsp_status), 64'(2));
        check("to_res", 64'(rsp_result), 64'(0));
        check("to_cshp", 64'(cur_shape), 64'(exp_cur_shape));
        check("to_cop", 64'(cur_operation), 64'(exp_cur_op));
        rsp_ready = 1'b1;
        exp_ptr = 1;
        idle_step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
